// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the serial ROM boot loader.
package rom_loader_pkg;

    // Width of the word-count header that precedes the image.
    localparam int LEN_WIDTH  = 16;
    // Width of one instruction-memory word.
    localparam int WORD_WIDTH = 32;

    // Loader FSM encodings (3 bits).
    typedef enum logic [2:0] {
        LOADER_LEN_LO = 3'd0,
        LOADER_LEN_HI = 3'd1,
        LOADER_DATA   = 3'd2,
        LOADER_DONE   = 3'd3,
        LOADER_ERROR  = 3'd4
    } loader_state_t;

    // UART receiver sample FSM encodings.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rom_loader_if.sv
// Instruction-memory write port driven by the boot loader.
interface rom_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                                 mem_we;
    logic [ADDR_WIDTH-1:0]                mem_addr;
    logic [rom_loader_pkg::WORD_WIDTH-1:0] mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/rom_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch filter,
// bit-centre sampling, one-cycle byte_valid / frame_err pulses.
module uart_rx
    import rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic             rx_s1, rx_s2, rx_prev;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_d, ferr_d;
    logic             fall_edge;

    assign fall_edge = rx_prev & ~rx_s2;
    assign byte_data = shift_q;

    // Synchronize rx and keep one delayed copy for falling-edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Receiver state, counters and output pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_valid <= valid_d;
            frame_err  <= ferr_d;
        end
    end

    // Next-state and sampling decisions.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall_edge) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_d = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_s2;
                    ferr_d  = ~rx_s2;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: parses a word-count header and a little-endian word stream
// from the UART, writes consecutive instruction-memory words and releases
// the CPU once the whole image is in place.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10,
    parameter int MAX_WORDS    = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    rom_loader_if.master mem,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  frame_err;

    loader_state_t         state_q, state_d;
    logic [7:0]            len_lo_q;
    logic [LEN_WIDTH-1:0]  len_full;
    logic [LEN_WIDTH-1:0]  word_cnt_q;
    logic [1:0]            byte_idx_q;
    logic [WORD_WIDTH-1:0] asm_q, asm_next;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign len_full      = {byte_data, len_lo_q};
    assign asm_next      = {byte_data, asm_q[WORD_WIDTH-1:8]};
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Loader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOADER_LEN_LO;
        else     state_q <= state_d;
    end

    // Header parsing, completion and fault transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOADER_LEN_LO: begin
                if (frame_err)       state_d = LOADER_ERROR;
                else if (byte_valid) state_d = LOADER_LEN_HI;
            end
            LOADER_LEN_HI: begin
                if (frame_err) begin
                    state_d = LOADER_ERROR;
                end else if (byte_valid) begin
                    if (len_full == '0)                         state_d = LOADER_DONE;
                    else if (len_full > LEN_WIDTH'(MAX_WORDS))  state_d = LOADER_ERROR;
                    else                                        state_d = LOADER_DATA;
                end
            end
            LOADER_DATA: begin
                // The count only reaches zero after the final write has issued,
                // so completion lands one cycle after the last mem_we.
                if (word_cnt_q == '0)  state_d = LOADER_DONE;
                else if (frame_err)    state_d = LOADER_ERROR;
            end
            LOADER_DONE, LOADER_ERROR: state_d = state_q;
            default:                   state_d = LOADER_ERROR;
        endcase
    end

    // Word assembly, write strobe, address counter and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lo_q   <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) addr_q <= addr_q + ADDR_WIDTH'(1);

            case (state_q)
                LOADER_LEN_LO: if (byte_valid) len_lo_q <= byte_data;
                LOADER_LEN_HI: if (byte_valid) word_cnt_q <= len_full;
                LOADER_DATA: begin
                    if (byte_valid && word_cnt_q != '0) begin
                        asm_q      <= asm_next;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            we_q       <= 1'b1;
                            wdata_q    <= asm_next;
                            word_cnt_q <= word_cnt_q - LEN_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase

            done     <= (state_d == LOADER_DONE);
            error    <= (state_d == LOADER_ERROR);
            cpu_hold <= (state_d != LOADER_DONE);
        end
    end

endmodule
